range_reader: RTL and testbench
===============================

// Module: range_reader
// PURPOSE
//  Reader/initiator for the range block. Launches a range run at a base number,
//  waits for its results RAM to fill, then reads the RAM back through range's
//  start/count read port, one word at a time.
//  Streams (n, count) pairs out on a valid/ready interface to downstream logic
//  (display, host bridge). The block is the drain side of range's write-only fill.
// PARAMETERS
//  RAM_WORDS      16  number of result words range stores; entries read per run
//  RAM_ADDR_BITS  4   range RAM address width; RAM_WORDS == 2**RAM_ADDR_BITS
// PORTS
//  clk          in   1   clock; all logic on rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  req          in   1   1-cycle pulse: start run at base (ignored while busy)
//  base         in   32  first number to test; sampled when req accepted
//  busy         out  1   high from req acceptance until last word accepted
//  range_go     out  1   to range.go
//  range_start  out  32  to range.start (base, or read address)
//  range_done   in   1   from range.done
//  range_count  in   16  from range.count (registered RAM read, 1-cycle latency)
//  out_valid    out  1   output word valid
//  out_ready    in   1   downstream accepts when valid&ready
//  out_n        out  32  number this count belongs to = base_q + idx (mod 2^32)
//  out_count    out  16  Collatz iteration count read from RAM
//  out_last     out  1   high with final word (idx == RAM_WORDS-1)
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, range_go=0, range_start=0, out_valid=0,
//   out_n=0, out_count=0, out_last=0, idx=0, base_q=0.
//  FSM (one transition per clk):
//   IDLE:    req=1 -> base_q<=base, idx<=0, busy<=1, go LAUNCH.
//   LAUNCH:  range_go=1, range_start=base_q for this cycle only -> ARM.
//   ARM:     range_go=0; one dead cycle; stale range_done from a prior run is
//            ignored here -> WAIT.
//   WAIT:    range_done=1 -> ADDR; else stay. No timeout.
//   ADDR:    range_start={zeros,idx} (zero-extended) -> CAPT.
//   CAPT:    range_start held; out_count<=range_count, out_n<=base_q+idx,
//            out_last<=(idx==RAM_WORDS-1), out_valid<=1 -> PRESENT.
//   PRESENT: out_* held stable while out_valid & !out_ready.
//            On valid&ready: out_valid<=0.
//             If last: busy<=0, go IDLE.
//             Else: idx<=idx+1, go ADDR.
//  range_go is high exactly one cycle per accepted req.
//  range_start low bits equal idx from ADDR through PRESENT; RAM word idx is
//   read, never written, during drain (range.we=0 after done).
//  Minimum 3 cycles per word (ADDR, CAPT, PRESENT with ready=1).
//  out_valid never drops without a handshake; never asserted outside PRESENT.
//  req while busy: ignored, no effect on base_q or the current run.
//  req in the same cycle as the final handshake: ignored (FSM in PRESENT).
//  out_n arithmetic is 32-bit modular: base 32'hFFFF_FFFF, idx 1 -> out_n 0.
//  idx wraps only via return to IDLE; never exceeds RAM_WORDS-1.
//  reset_n low mid-run: all outputs to reset values immediately (async).
//   range has no reset; the next req relaunches it via range_go.
// CONFIGURATION
//  MAX_TRACK_EN defined: adds outputs max_count[15:0], max_n[31:0], max_valid.
//   Cleared to 0 at req acceptance; updated at each CAPT when
//   range_count > max_count (strict, so ties keep the earlier n).
//   max_valid<=1 with the last handshake; held until next req or reset.
//  MAX_TRACK_EN undefined: these ports and their registers do not exist;
//   all other behaviour is identical.
// TESTING (range stub: mem[i]=100+i, done rises 20 clk after go; real-range run too)
//  1 reset_n=0 mid-WAIT -> all outputs 0 within same cycle; a fresh req then
//    gives exactly one range_go pulse.
//  2 req, base=10, out_ready=1 -> one range_go with range_start=10; 16 words,
//    out_n=10..25, out_count=100..115, out_last only on the 16th; busy falls after.
//  3 out_ready toggled randomly -> out_n/out_count/out_last stable while
//    valid&!ready; no word lost or duplicated; 16 handshakes total.
//  4 second req during drain; stale range_done=1 held at launch -> second req
//    ignored; ARM prevents early exit from WAIT; drain starts only after done
//    re-rises.
//  5 base=32'hFFFF_FFF8 -> out_n wraps ...FFFF then 0..7; address still 0..15.
//  6 MAX_TRACK_EN with real range, base=1 -> max_n=9, max_valid=1 after the
//    last handshake; max_count equals the largest out_count streamed.

Source files
------------

// File: rtl/range_reader.sv
// range_reader: launches a range run at a base number, waits for done,
// then drains the 16-word result RAM as (n, count) words on valid/ready.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   req, base, busy         run request (1-cycle pulse), base number, run active
//   range_go, range_start   launch pulse and base / read address to range
//   range_done, range_count range completion and registered RAM read data
//   out_valid, out_ready    output handshake
//   out_n, out_count        number and its iteration count
//   out_last                final word of a run
//   max_count, max_n,       largest count seen in the run, its n, and a flag
//   max_valid               set on the final handshake
//                           (these three exist only with MAX_TRACK_EN defined)
module range_reader #(
    parameter int RAM_WORDS     = 16,
    parameter int RAM_ADDR_BITS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic [31:0] base,
    output logic        busy,
    output logic        range_go,
    output logic [31:0] range_start,
    input  logic        range_done,
    input  logic [15:0] range_count,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_n,
    output logic [15:0] out_count,
`ifdef MAX_TRACK_EN
    output logic        out_last,
    output logic [15:0] max_count,
    output logic [31:0] max_n,
    output logic        max_valid
`else
    output logic        out_last
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_ARM,
        S_WAIT,
        S_ADDR,
        S_CAPT,
        S_PRESENT
    } state_t;

    localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX =
        RAM_ADDR_BITS'(RAM_WORDS - 1);

    state_t                   state;
    state_t                   state_nxt;
    logic [RAM_ADDR_BITS-1:0] idx;
    logic [31:0]              base_q;
    logic [31:0]              idx_ext;
    logic [31:0]              n_cur;
    logic                     hs;

    assign idx_ext = {{(32 - RAM_ADDR_BITS){1'b0}}, idx};
    assign n_cur   = base_q + idx_ext;
    assign hs      = out_valid && out_ready;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (req) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: state_nxt = S_ARM;
            // A done left high by the previous run is not trusted here.
            S_ARM:    state_nxt = S_WAIT;
            S_WAIT: begin
                if (range_done) state_nxt = S_ADDR;
            end
            S_ADDR:   state_nxt = S_CAPT;
            S_CAPT:   state_nxt = S_PRESENT;
            S_PRESENT: begin
                if (hs) state_nxt = out_last ? S_IDLE : S_ADDR;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        range_go    = 1'b0;
        range_start = 32'd0;
        unique case (state)
            S_LAUNCH: begin
                range_go    = 1'b1;
                range_start = base_q;
            end
            // Address is held through CAPT/PRESENT so the read port
            // keeps pointing at the word being presented.
            S_ADDR, S_CAPT, S_PRESENT: begin
                range_start = idx_ext;
            end
            default: begin
                range_go    = 1'b0;
                range_start = 32'd0;
            end
        endcase
    end

    // Run datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy      <= 1'b0;
            idx       <= '0;
            base_q    <= 32'd0;
            out_valid <= 1'b0;
            out_n     <= 32'd0;
            out_count <= 16'd0;
            out_last  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        base_q <= base;
                        idx    <= '0;
                        busy   <= 1'b1;
                    end
                end
                S_CAPT: begin
                    out_count <= range_count;
                    out_n     <= n_cur;
                    out_last  <= (idx == LAST_IDX);
                    out_valid <= 1'b1;
                end
                S_PRESENT: begin
                    if (hs) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            busy <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MAX_TRACK_EN
    // Running maximum; strict compare keeps the earliest n on ties.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            max_count <= 16'd0;
            max_n     <= 32'd0;
            max_valid <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        max_count <= 16'd0;
                        max_n     <= 32'd0;
                        max_valid <= 1'b0;
                    end
                end
                S_CAPT: begin
                    if (range_count > max_count) begin
                        max_count <= range_count;
                        max_n     <= n_cur;
                    end
                end
                S_PRESENT: begin
                    if (hs && out_last) max_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_range_reader.sv
// Bench for range_reader with a behavioural range stub:
// registered RAM read, done rises ~20 clocks after go.
module tb_range_reader;

    typedef struct {
        logic [31:0] n;
        logic [15:0] c;
        logic        l;
        logic [3:0]  a;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0;
    logic [31:0] base = 32'd0;
    logic        busy;
    logic        range_go;
    logic [31:0] range_start;
    logic        range_done = 1'b0;
    logic [15:0] range_count = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_n;
    logic [15:0] out_count;
    logic        out_last;
`ifdef MAX_TRACK_EN
    logic [15:0] max_count;
    logic [31:0] max_n;
    logic        max_valid;
`endif

    int checks = 0;
    int failures = 0;

    exp_t        sb[$];
    logic [15:0] mem[16];

    int          go_cnt = 0;
    logic [31:0] go_start = 32'd0;
    int          early_cnt = 0;
    int          stab_err = 0;

    logic        st_pend = 1'b0;
    int          st_cnt = 0;

    range_reader dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .base        (base),
        .busy        (busy),
        .range_go    (range_go),
        .range_start (range_start),
        .range_done  (range_done),
        .range_count (range_count),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_n       (out_n),
        .out_count   (out_count),
`ifdef MAX_TRACK_EN
        .out_last    (out_last),
        .max_count   (max_count),
        .max_n       (max_n),
        .max_valid   (max_valid)
`else
        .out_last    (out_last)
`endif
    );

    always #5 clk = ~clk;

    // Range stub: done stays high after a run and only drops one
    // cycle after go has been seen, like a slow real block.
    always @(posedge clk) begin
        range_count <= mem[range_start[3:0]];
        if (range_go) begin
            st_pend <= 1'b1;
        end else if (st_pend) begin
            st_pend    <= 1'b0;
            range_done <= 1'b0;
            st_cnt     <= 18;
        end else if (st_cnt != 0) begin
            st_cnt <= st_cnt - 1;
            if (st_cnt == 1) range_done <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (range_go) begin
            go_cnt   <= go_cnt + 1;
            go_start <= range_start;
        end
        if (out_valid && (st_pend || st_cnt != 0)) early_cnt <= early_cnt + 1;
    end

    logic        hold_f = 1'b0;
    logic [31:0] snap_n;
    logic [15:0] snap_c;
    logic        snap_l;

    always begin
        @(negedge clk);
        #2;
        if (hold_f) begin
            if (!out_valid || out_n !== snap_n ||
                out_count !== snap_c || out_last !== snap_l)
                stab_err++;
        end
        hold_f = reset_n && out_valid && !out_ready;
        snap_n = out_n;
        snap_c = out_count;
        snap_l = out_last;
    end

    function automatic logic [15:0] collatz(input logic [31:0] n);
        logic [31:0] v = n;
        logic [15:0] s = 0;
        while (v != 1) begin
            v = v[0] ? 3 * v + 1 : v >> 1;
            s++;
        end
        return s;
    endfunction

    task automatic start_run(input logic [31:0] b);
        @(negedge clk);
        base = b;
        req  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_t e;
            e.n = b + 32'(i);
            e.c = mem[i];
            e.l = (i == 15);
            e.a = 4'(i);
            sb.push_back(e);
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic drain(input bit rnd, input int inj_at,
                         input logic [31:0] inj_base);
        int  got = 0;
        int  cyc = 0;
        bit  inj = 0;
        bit  hs;
        while (got < 16 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            req = 1'b0;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            hs = out_valid && out_ready;
            if (inj_at >= 0 && !inj && got == inj_at && (inj_at < 15 || hs)) begin
                inj  = 1;
                base = inj_base;
                req  = 1'b1;
            end
            if (hs) begin
                exp_t e;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_empty: unexpected word n=%h", out_n);
                end else begin
                    e = sb.pop_front();
                    checks += 3;
                    if (out_n !== e.n) begin
                        failures++;
                        $display("FAIL out_n: got %h want %h", out_n, e.n);
                    end
                    if (out_count !== e.c) begin
                        failures++;
                        $display("FAIL out_count: got %0d want %0d", out_count, e.c);
                    end
                    if (out_last !== e.l) begin
                        failures++;
                        $display("FAIL out_last: got %b want %b", out_last, e.l);
                    end
                    if (range_start !== {28'd0, e.a}) begin
                        failures++;
                        $display("FAIL addr: got %h want %h", range_start, e.a);
                    end
                end
                got++;
            end
        end
        @(negedge clk);
        req = 1'b0;
        checks++;
        if (got < 16) begin
            failures++;
            $display("FAIL drain_timeout: got %0d words want 16", got);
            sb.delete();
        end
    endtask

    task automatic check_idle(input string tag, input int go_exp);
        repeat (3) @(negedge clk);
        #1;
        checks += 4;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy: got %b want 0", tag, busy);
        end
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_valid: got %b want 0", tag, out_valid);
        end
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_left: got %0d want 0", tag, sb.size());
        end
        if (go_cnt !== go_exp) begin
            failures++;
            $display("FAIL %s_go: got %0d want %0d", tag, go_cnt, go_exp);
        end
    endtask

    task automatic test_reset_state;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy, range_go, range_start, out_valid, out_n, out_count, out_last}
            !== '0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b go=%b start=%h v=%b n=%h c=%h l=%b want 0",
                     busy, range_go, range_start, out_valid, out_n, out_count, out_last);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic;
        int g0 = go_cnt;
        start_run(32'd10);
        #1;
        checks += 2;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy: got %b want 1", busy);
        end
        @(negedge clk);
        if (go_start !== 32'd10) begin
            failures++;
            $display("FAIL basic_go_start: got %h want 0000000a", go_start);
        end
        drain(0, -1, 0);
        check_idle("basic", g0 + 1);
    endtask

    task automatic test_reset;
        int g0;
        start_run(32'h55);
        repeat (6) @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, range_go, range_start, out_valid, out_n, out_count, out_last}
            !== '0) begin
            failures++;
            $display("FAIL reset_async: got busy=%b n=%h c=%h l=%b want 0",
                     busy, out_n, out_count, out_last);
        end
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        g0 = go_cnt;
        start_run(32'h20);
        drain(0, -1, 0);
        check_idle("relaunch", g0 + 1);
    endtask

    task automatic test_random_ready;
        int g0 = go_cnt;
        int s0 = stab_err;
        start_run(32'h1000);
        drain(1, -1, 0);
        check_idle("random", g0 + 1);
        checks++;
        if (stab_err !== s0) begin
            failures++;
            $display("FAIL stable: got %0d errors want %0d", stab_err, s0);
        end
    endtask

    task automatic test_stale_done;
        int g0 = go_cnt;
        int e0 = early_cnt;
        checks++;
        if (range_done !== 1'b1) begin
            failures++;
            $display("FAIL stale_setup: got done=%b want 1", range_done);
        end
        start_run(32'd300);
        drain(1, 5, 32'd999);
        check_idle("second_req", g0 + 1);
        checks++;
        if (early_cnt !== e0) begin
            failures++;
            $display("FAIL early_drain: got %0d want %0d", early_cnt, e0);
        end
    endtask

    task automatic test_wrap;
        int g0 = go_cnt;
        start_run(32'hFFFF_FFF8);
        drain(1, 15, 32'd7);
        check_idle("wrap", g0 + 1);
    endtask

`ifdef MAX_TRACK_EN
    task automatic test_max;
        for (int i = 0; i < 16; i++) mem[i] = collatz(32'(i + 1));
        start_run(32'd1);
        drain(1, -1, 0);
        check_idle("max", go_cnt);
        checks += 3;
        if (max_n !== 32'd9) begin
            failures++;
            $display("FAIL max_n: got %0d want 9", max_n);
        end
        if (max_count !== 16'd19) begin
            failures++;
            $display("FAIL max_count: got %0d want 19", max_count);
        end
        if (max_valid !== 1'b1) begin
            failures++;
            $display("FAIL max_valid: got %b want 1", max_valid);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'(100 + i);
        test_reset_state();
        test_basic();
        test_reset();
        test_random_ready();
        test_stale_done();
        test_wrap();
`ifdef MAX_TRACK_EN
        test_max();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
